// File: rtl/wash_phase_timer.sv
// -----------------------------------------------------------------------------
// wash_phase_timer
//
// Times one wash/rinse ("cycle") phase or one spin phase for the washer
// controller. A free-running prescaler divides the clock into ticks of
// PRESCALE clocks. A down-counter loaded with the requested duration counts
// those ticks. The matching timeout output is raised when the counter expires
// and held until the request drops.
//
// Parameters
//   PRESCALE    clocks per tick, legal range 2..65535
//   CNT_W       width of the duration inputs and of the remaining output
//
// Ports
//   clock          in   rising-edge system clock
//   reset          in   asynchronous active-low reset; release is synchronised
//   cycle_req      in   level request to time a cycle phase
//   spin_req       in   level request to time a spin phase
//   door_lock      in   low freezes prescaler and counter while running
//   abort          in   synchronous abort back to idle, overrides all inputs
//   cycle_time     in   cycle duration in ticks, sampled on phase entry
//   spin_time      in   spin duration in ticks, sampled on phase entry
//   cycle_timeout  out  registered, high while the cycle phase has expired
//   spin_timeout   out  registered, high while the spin phase has expired
//   busy           out  registered, high while a phase is running
//   remaining      out  registered copy of the down-counter
// -----------------------------------------------------------------------------
module wash_phase_timer #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cycle_req,
  input  logic             spin_req,
  input  logic             door_lock,
  input  logic             abort,
  input  logic [CNT_W-1:0] cycle_time,
  input  logic [CNT_W-1:0] spin_time,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCycRun,
    StCycDone,
    StSpinRun,
    StSpinDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  presc_q, presc_d;

  logic             cycle_timeout_q, cycle_timeout_d;
  logic             spin_timeout_q, spin_timeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // ---------------------------------------------------------------------------
  // Reset release synchroniser. Assertion is immediate; release ripples
  // through two flops so no state update can happen before the second rising
  // edge after deassertion, whatever the phase of the external reset.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       run_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_en = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State register, datapath registers and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      presc_q         <= '0;
      cycle_timeout_q <= 1'b0;
      spin_timeout_q  <= 1'b0;
      busy_q          <= 1'b0;
      remaining_q     <= '0;
    end else if (run_en) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      presc_q         <= presc_d;
      cycle_timeout_q <= cycle_timeout_d;
      spin_timeout_q  <= spin_timeout_d;
      busy_q          <= busy_d;
      remaining_q     <= remaining_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  logic tick;
  assign tick = (presc_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        if (cycle_req) begin
          cnt_d   = cycle_time;
          state_d = (cycle_time == '0) ? StCycDone : StCycRun;
        end else if (spin_req) begin
          cnt_d   = spin_time;
          state_d = (spin_time == '0) ? StSpinDone : StSpinRun;
        end
      end

      StCycRun, StSpinRun: begin
        // Only the request that started the phase matters here.
        if ((state_q == StCycRun) ? !cycle_req : !spin_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          presc_d = '0;
        end else if (door_lock) begin
          if (tick) begin
            presc_d = '0;
            // The <= guard keeps the counter from wrapping even if a
            // zero ever reached a run state.
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = (state_q == StCycRun) ? StCycDone : StSpinDone;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
        end
      end

      StCycDone: begin
        cnt_d   = '0;
        presc_d = '0;
        if (!cycle_req) begin
          state_d = StIdle;
        end
      end

      StSpinDone: begin
        cnt_d   = '0;
        presc_d = '0;
        if (!spin_req) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        presc_d = '0;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      presc_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered outputs line
  // up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    cycle_timeout_d = (state_d == StCycDone);
    spin_timeout_d  = (state_d == StSpinDone);
    busy_d          = (state_d == StCycRun) || (state_d == StSpinRun);
    remaining_d     = cnt_d;
  end

  assign cycle_timeout = cycle_timeout_q;
  assign spin_timeout  = spin_timeout_q;
  assign busy          = busy_q;
  assign remaining     = remaining_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_wash_phase_timer
//
// Drives directed phase scenarios followed by randomized stimulus. A phase
// model (elapsed active clocks versus duration * PRESCALE) predicts outputs,
// pushes them into a queue, and a separate monitor compares after each edge.
// -----------------------------------------------------------------------------
module tb_wash_phase_timer;

  localparam int unsigned P = 4;
  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cycle_req = 1'b0;
  logic         spin_req = 1'b0;
  logic         door_lock = 1'b1;
  logic         abort = 1'b0;
  logic [W-1:0] cycle_time = '0;
  logic [W-1:0] spin_time = '0;
  logic         cycle_timeout;
  logic         spin_timeout;
  logic         busy;
  logic [W-1:0] remaining;

  wash_phase_timer #(
    .PRESCALE(P),
    .CNT_W   (W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cycle_req    (cycle_req),
    .spin_req     (spin_req),
    .door_lock    (door_lock),
    .abort        (abort),
    .cycle_time   (cycle_time),
    .spin_time    (spin_time),
    .cycle_timeout(cycle_timeout),
    .spin_timeout (spin_timeout),
    .busy         (busy),
    .remaining    (remaining)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         ct;
    logic         st;
    logic         bz;
    logic [W-1:0] rem;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_cycle = 0;

  // Phase model: kind 0 idle, 1 cycle, 2 spin.
  int   m_kind = 0;
  bit   m_done = 1'b0;
  int   m_dur = 0;
  int   m_el = 0;
  int   m_sync = 0;

  function automatic exp_t m_out();
    exp_t o;
    o.ct  = (m_kind == 1) && m_done;
    o.st  = (m_kind == 2) && m_done;
    o.bz  = (m_kind != 0) && !m_done;
    o.rem = (m_kind == 0 || m_done) ? '0 : W'(m_dur - m_el / P);
    return o;
  endfunction

  function automatic void m_start(input int k, input int n);
    m_kind = k;
    m_dur  = n;
    m_el   = 0;
    m_done = (n == 0);
  endfunction

  function automatic void m_update(input bit cr, input bit sr, input bit dl, input bit ab,
                                   input int ct, input int st);
    bit req;
    if (ab) begin
      m_kind = 0;
      m_done = 1'b0;
    end else if (m_kind == 0) begin
      if (cr) m_start(1, ct);
      else if (sr) m_start(2, st);
    end else begin
      req = (m_kind == 1) ? cr : sr;
      if (!req) begin
        m_kind = 0;
        m_done = 1'b0;
      end else if (!m_done && dl) begin
        m_el++;
        if (m_el == m_dur * P) m_done = 1'b1;
      end
    end
  endfunction

  // One clock of stimulus: inputs change at the falling edge, and the model
  // predicts the outputs seen after the following rising edge.
  task automatic step(input bit rst, input bit cr, input bit sr, input bit dl, input bit ab,
                      input int ct, input int st);
    bit was_high;
    @(negedge clock);
    was_high   = reset;
    reset      = rst;
    cycle_req  = cr;
    spin_req   = sr;
    door_lock  = dl;
    abort      = ab;
    cycle_time = W'(ct);
    spin_time  = W'(st);
    if (!rst) begin
      m_kind = 0;
      m_done = 1'b0;
      m_sync = 0;
    end else if (m_sync >= 2) begin
      m_update(cr, sr, dl, ab, ct, st);
    end else begin
      m_sync++;
    end
    q.push_back(m_out());
    if (was_high && !rst) begin
      #1;
      n_checks++;
      if (cycle_timeout === 1'b0 && spin_timeout === 1'b0 && busy === 1'b0 &&
          remaining === '0) begin
        n_pass++;
      end else begin
        $display("FAIL async_reset got ct=%b st=%b busy=%b rem=%0d want all 0",
                 cycle_timeout, spin_timeout, busy, remaining);
      end
    end
  endtask

  // Monitor: compares DUT outputs against the queued prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      n_cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (cycle_timeout === e.ct && spin_timeout === e.st && busy === e.bz &&
            remaining === e.rem) begin
          n_pass++;
        end else begin
          $display("FAIL outputs@clk%0d got ct=%b st=%b busy=%b rem=%0d want ct=%b st=%b busy=%b rem=%0d",
                   n_cycle, cycle_timeout, spin_timeout, busy, remaining,
                   e.ct, e.st, e.bz, e.rem);
        end
      end
    end
  end

  initial begin
    bit rst, cr, sr, dl, ab;
    int ct, st;

    // Power-on reset, then release and let the synchroniser settle.
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1, 0, 0, 0);

    // Cycle phase of 3 ticks held past expiry, then released.
    repeat (16) step(1, 1, 0, 1, 0, 3, 0);
    repeat (3) step(1, 0, 0, 1, 0, 3, 0);

    // Spin phase of 5 ticks with door unlocked for 6 clocks mid-run.
    repeat (6) step(1, 0, 1, 1, 0, 0, 5);
    repeat (6) step(1, 0, 1, 0, 0, 0, 5);
    repeat (22) step(1, 0, 1, 1, 0, 0, 5);
    repeat (2) step(1, 0, 0, 1, 0, 0, 5);

    // Both requests together: cycle wins, spin ignored.
    repeat (11) step(1, 1, 1, 1, 0, 2, 3);
    repeat (3) step(1, 0, 0, 1, 0, 2, 3);

    // Zero duration goes straight to timeout.
    repeat (3) step(1, 1, 0, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0, 0);

    // Abort at remaining 2, re-entry, then reset mid-phase.
    repeat (13) step(1, 1, 0, 1, 0, 5, 0);
    step(1, 1, 0, 1, 1, 5, 0);
    repeat (6) step(1, 1, 0, 1, 0, 5, 0);
    step(0, 1, 0, 1, 0, 5, 0);
    repeat (4) step(1, 0, 0, 1, 0, 5, 0);
    repeat (7) step(1, 0, 1, 1, 0, 0, 1);
    repeat (2) step(1, 0, 0, 1, 0, 0, 1);

    // Cycle request dropped at remaining 1.
    repeat (9) step(1, 1, 0, 1, 0, 3, 0);
    repeat (4) step(1, 0, 0, 1, 0, 3, 0);

    // Randomized stimulus with slowly changing requests.
    rst = 1'b1; cr = 1'b0; sr = 1'b0; ct = 2; st = 3;
    for (int i = 0; i < 3000; i++) begin
      if (!rst) rst = ($urandom_range(0, 1) == 1);
      else rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 11) == 0) cr = ~cr;
      if ($urandom_range(0, 11) == 0) sr = ~sr;
      dl = ($urandom_range(0, 5) != 0);
      ab = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) ct = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) st = int'($urandom_range(0, 5));
      step(rst, cr, sr, dl, ab, ct, st);
    end

    repeat (3) @(posedge clock);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 Parameter PRESCALE, default 1000, clocks per time unit (tick); legal range 2..65535.
REQ-002 Parameter CNT_W, default 8, width of the duration and remaining-count fields.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cycle_req  input  1  level request to time a wash/rinse cycle phase (driven from controller motor_on).
REQ-006 spin_req  input  1  level request to time a spin phase.
REQ-007 door_lock  input  1  controller door lock; low freezes all timing.
REQ-008 abort  input  1  synchronous abort; returns block to IDLE.
REQ-009 cycle_time  input  CNT_W  cycle duration in ticks, sampled on phase entry only.
REQ-010 spin_time  input  CNT_W  spin duration in ticks, sampled on phase entry only.
REQ-011 cycle_timeout  output  1  registered; high while cycle phase has expired.
REQ-012 spin_timeout  output  1  registered; high while spin phase has expired.
REQ-013 busy  output  1  registered; high in CYC_RUN or SPIN_RUN.
REQ-014 remaining  output  CNT_W  registered; current down-counter value.

Function
REQ-015 States SHALL be IDLE, CYC_RUN, CYC_DONE, SPIN_RUN, SPIN_DONE; all outputs registered, no combinational output paths.
REQ-016 IDLE: cycle_req=1 -> CYC_RUN, counter<=cycle_time, prescaler<=0; else spin_req=1 -> SPIN_RUN, counter<=spin_time, prescaler<=0; cycle_req wins if both high.
REQ-017 Zero duration: in IDLE, request with duration 0 SHALL go directly to the matching DONE state, timeout high one clock after the request is sampled.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 in RUN states; tick is the clock where prescaler==PRESCALE-1, prescaler wraps to 0.
REQ-019 On each tick counter SHALL decrement by 1; on tick with counter==1, state -> DONE and counter<=0 on the same edge.
REQ-020 Latency: timeout SHALL rise exactly N*PRESCALE clocks after the RUN-entry edge for duration N>=1 with door_lock continuously high.
REQ-021 door_lock=0 in a RUN state SHALL freeze prescaler and counter (state held); timing resumes from the frozen values when door_lock returns high.
REQ-022 Request dropped in RUN state (cycle_req=0 in CYC_RUN, spin_req=0 in SPIN_RUN) SHALL return to IDLE, counter<=0, no timeout pulse.
REQ-023 DONE states SHALL hold timeout high until the matching request drops, then go to IDLE with timeout low next clock.
REQ-024 The non-matching request SHALL be ignored in RUN and DONE states.
REQ-025 abort=1 SHALL override all other inputs: next state IDLE, counter and prescaler 0, all outputs low.
REQ-026 remaining SHALL equal the counter; busy high only in CYC_RUN/SPIN_RUN; cycle_timeout and spin_timeout never high together.
REQ-027 Counter SHALL never wrap below 0 nor load any value other than cycle_time/spin_time/0.

Reset
REQ-028 reset low SHALL immediately force state IDLE, counter 0, prescaler 0, and cycle_timeout, spin_timeout, busy, remaining all 0, independent of clock.
REQ-029 Reset release SHALL be synchronised internally so the first state update occurs no earlier than the second rising edge after deassertion.
REQ-030 Reset asserted mid-phase SHALL discard the phase; re-request after release restarts from the full sampled duration.

Verification (PRESCALE=4, CNT_W=8)
REQ-031 cycle_time=3, door_lock=1, cycle_req held -> busy high, remaining 3,2,1 at 4-clock spacing, cycle_timeout high 12 clocks after CYC_RUN entry, stays high until cycle_req drops.
REQ-032 spin_time=5, door_lock pulled low 6 clocks for 6 clocks mid-run -> spin_timeout rises at 20+6=26 clocks after entry.
REQ-033 cycle_req and spin_req rise together, cycle_time=2 -> CYC_RUN taken, cycle_timeout at 8 clocks, spin_timeout stays 0.
REQ-034 cycle_time=0 -> cycle_timeout high one clock after request, busy never high.
REQ-035 abort at remaining=2, then reset pulse low mid-phase -> outputs 0 immediately; re-request spin_time=1 -> spin_timeout at exactly 4 clocks after entry.
REQ-036 cycle_req dropped at remaining=1 -> IDLE, remaining 0, no cycle_timeout pulse observed.
